// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud-rate generator.
package baud_pkg;
    localparam int CNT_W    = 16;
    localparam int FRAC_W   = 4;
    localparam int DEF_INT  = 104;
    localparam int DEF_FRAC = 3;
    localparam bit DEF_OSR8 = 1'b0;
    localparam int MIN_DIV  = 2;

    typedef enum logic {
        OSR16 = 1'b0,
        OSR8  = 1'b1
    } osr_e;
endpackage

// File: rtl/baud_frac_divider.sv
// Fractional clock divider: INT or INT+1 cycle periods selected by a phase accumulator.
module baud_frac_divider #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);
    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic [CNT_W:0]    len;
    logic              last;

    assign acc_sum = {1'b0, acc} + {1'b0, div_frac};
    assign len     = {1'b0, div_int} + (CNT_W+1)'(acc_sum[FRAC_W]);
    assign last    = ({1'b0, cnt} == len - (CNT_W+1)'(1));

    // Look-ahead strobe: fires one cycle before the period's final cycle so the
    // caller's output register lands on that final cycle. A clear in this cycle
    // therefore suppresses the tick of the period being abandoned.
    assign tick = ~clear & ({1'b0, cnt} == len - (CNT_W+1)'(2));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (last) begin
            cnt <= '0;
            acc <= acc_sum[FRAC_W-1:0];
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/baud_rate_generator.sv
// Programmable fractional baud generator: TX bit tick, RX oversample tick and RX mid-bit strobe.
module baud_rate_generator #(
    parameter int   CNT_W    = baud_pkg::CNT_W,
    parameter int   FRAC_W   = baud_pkg::FRAC_W,
    parameter int   DEF_INT  = baud_pkg::DEF_INT,
    parameter int   DEF_FRAC = baud_pkg::DEF_FRAC,
    parameter logic DEF_OSR8 = baud_pkg::DEF_OSR8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              osr8,
    input  logic              rx_resync,
    output logic              rx_tick,
    output logic              rx_mid,
    output logic              tx_tick,
    output logic              cfg_err
);
    import baud_pkg::*;

    logic [CNT_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    osr_e              act_osr;
    logic [3:0]        tx_sub, rx_sub, sub_last, mid_last;
    logic              tx_end, rx_end, tx_clear, rx_clear;

    assign sub_last = (act_osr == OSR8) ? 4'd7 : 4'd15;
    assign mid_last = (act_osr == OSR8) ? 4'd3 : 4'd7;
    assign tx_clear = ~en;
    assign rx_clear = rx_resync | ~en;

    // Config only changes while stopped so a divider never sees it mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_int  <= CNT_W'(DEF_INT);
            act_frac <= FRAC_W'(DEF_FRAC);
            act_osr  <= osr_e'(DEF_OSR8);
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_load & en;
            if (cfg_load && !en) begin
                act_int  <= (div_int < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_int;
                act_frac <= div_frac;
                act_osr  <= osr_e'(osr8);
            end
        end
    end

    baud_frac_divider #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_tx_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (tx_clear),
        .div_int  (act_int),
        .div_frac (act_frac),
        .tick     (tx_end)
    );

    baud_frac_divider #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_rx_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (rx_clear),
        .div_int  (act_int),
        .div_frac (act_frac),
        .tick     (rx_end)
    );

    always_ff @(posedge clk) begin
        if (rst || tx_clear) begin
            tx_sub  <= '0;
            tx_tick <= 1'b0;
        end else begin
            tx_tick <= tx_end && (tx_sub == sub_last);
            if (tx_end)
                tx_sub <= (tx_sub == sub_last) ? 4'd0 : tx_sub + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_clear) begin
            rx_sub  <= '0;
            rx_tick <= 1'b0;
            rx_mid  <= 1'b0;
        end else begin
            rx_tick <= rx_end;
            rx_mid  <= rx_end && (rx_sub == mid_last);
            if (rx_end)
                rx_sub <= (rx_sub == sub_last) ? 4'd0 : rx_sub + 4'd1;
        end
    end
endmodule

// File: doc/baud_rate_generator.md
# baud_rate_generator

Programmable fractional baud-rate generator replacing the fixed compile-time divider in the UART path. It produces a TX bit tick, an RX oversample tick and an RX mid-bit sample strobe from one system clock, using a runtime-loadable divisor with a fractional part and 16x or 8x oversampling. The RX phase can be realigned to a detected start-bit edge without disturbing TX timing. It sits between the APB UART register block (configuration) and the UART TX/RX state machines (tick consumers).

## Interface
- CNT_W, 16: width of integer divisor field `div_int`.
- FRAC_W, 4: width of fractional divisor field `div_frac`, in units of 1/2^FRAC_W.
- DEF_INT, 104: integer divisor after reset (16 MHz clock, 9600 baud, 16x oversampling).
- DEF_FRAC, 3: fractional divisor after reset.
- DEF_OSR8, 0: oversampling mode after reset; 0 = 16x, 1 = 8x.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; 0 holds all counters cleared.
- cfg_load  in  1  one-cycle strobe that captures div_int, div_frac and osr8.
- div_int  in  CNT_W  integer divisor, in clk cycles per oversample period.
- div_frac  in  FRAC_W  fractional divisor.
- osr8  in  1  oversampling select; 0 = 16x, 1 = 8x.
- rx_resync  in  1  one-cycle strobe on a start-bit falling edge; restarts the RX phase.
- rx_tick  out  1  RX oversample tick, one-cycle pulse.
- rx_mid  out  1  RX mid-bit sample strobe, one-cycle pulse, coincident with an rx_tick.
- tx_tick  out  1  TX bit-period tick, one-cycle pulse.
- cfg_err  out  1  one-cycle pulse when cfg_load arrives while en=1.

## Operation
- Active config consists of INT, FRAC and OSR. OSR is 16 or 8.
- On reset, the active config loads DEF_INT, DEF_FRAC and DEF_OSR8.
- cfg_load with en=0: the active config updates on the next cycle.
- cfg_load with en=1: the load is ignored, the active config is unchanged, and cfg_err pulses on the next cycle.
- div_int values 0 and 1 are clamped to 2 at capture.
- The block contains two independent fractional dividers, TX and RX, both driven from the same active config.
- Each divider has a CNT_W-bit cycle counter and a FRAC_W-bit accumulator `acc`.
  - At the start of each period, carry = (acc + FRAC ≥ 2^FRAC_W).
  - Period length = INT + carry.
  - At period end, the divider emits its oversample tick and sets acc ← (acc + FRAC) mod 2^FRAC_W.
  - Long-run average period = INT + FRAC/2^FRAC_W.
- TX path:
  - A sub-counter counts 0..OSR-1 on TX oversample ticks.
  - tx_tick asserts on the oversample tick that completes count OSR-1.
- RX path:
  - rx_tick is the RX divider's oversample tick.
  - The RX sub-counter counts 0..OSR-1.
  - rx_mid asserts on the rx_tick that completes count OSR/2-1.
- rx_resync clears the RX cycle counter, RX accumulator and RX sub-counter. It has no effect on the TX path.
- rx_resync in the same cycle as an RX period end: resync wins and that rx_tick and rx_mid are suppressed.
- Falling en clears all counters and accumulators. Rising en starts both dividers from zero phase.
- rst overrides en, cfg_load and rx_resync.

## Timing
- All outputs are registered and are 0 during and after reset until the first tick.
- With en=1 from cycle 0 (first enabled cycle), the first oversample tick of each divider asserts in cycle INT-1+carry.
- After rx_resync in cycle t, RX counting restarts in cycle t+1.
- cfg_err asserts one cycle after the offending cfg_load.
- With reset defaults (INT=104, FRAC=3, OSR=16), periods 6, 11 and 16 of every 16 are extended by one cycle. tx_tick is therefore exactly every 1667 clk cycles.

## Structure
- Package `baud_pkg` holds:
  - CNT_W, FRAC_W and DEF_* constants;
  - OSR encoding constants (OSR16=0, OSR8=1);
  - the clamp minimum (2).
- Sub-module `baud_frac_divider` implements the cycle counter, fractional accumulator and tick output, with a sync clear input.
  - It is instantiated twice: TX, and RX with clear = rx_resync | ~en.
- The top level holds the active config registers, the cfg_err logic and the two sub-counters.

## Test plan
- Reset behaviour: assert rst for 3 cycles with en=1 → all outputs 0. Release rst → first rx_tick at cycle 103, tx_tick every 1667 cycles, 10 consecutive periods checked.
- Integer-only divisor, 8x: en=0, cfg_load with div_int=10, div_frac=0, osr8=1; then en=1 → rx_tick every 10 cycles, tx_tick every 80 cycles, rx_mid 40 cycles after each rx phase start.
- RX resync under defaults: pulse rx_resync mid-bit → rx_mid 833 cycles after the resync cycle (8 periods, one extended), then every 1667 cycles. tx_tick spacing stays at 1667, unperturbed.
- Config guard: cfg_load with div_int=50 while en=1 → cfg_err pulse one cycle later and tx_tick spacing remains 1667. Repeat with en=0, then set en=1 → rx_tick every 50 cycles.
- Clamp: load div_int=0 then div_int=1 → rx_tick every 2 cycles in both cases.
- Mid-operation reset and collision: assert rst mid-stream → outputs 0 next cycle and config back to defaults. Drive rx_resync in the same cycle as an rx_tick → tick suppressed, next rx_tick 104 cycles later.
